kara64_seq_ctrl: RTL and testbench
==================================

// Module: kara64_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer computing an unsigned 64x64->128 product with Karatsuba over 3 passes
//  through ONE shared 33x33 combinational multiplier, replacing the full-width Wallace tree
//  where area matters. Sits between an upstream operand source and a downstream consumer,
//  with valid/ready handshakes on both sides.
// PARAMETERS
//  W      64   operand width; must be even, >= 4; product is 2*W, half-width H = W/2
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous reset, active-high
//  in_valid   in   1      operands A,B are valid
//  in_ready   out  1      block can accept operands (IDLE only)
//  A          in   W      multiplicand, unsigned
//  B          in   W      multiplier, unsigned
//  out_valid  out  1      P holds a completed product
//  out_ready  in   1      consumer accepts P
//  P          out  2W     product A*B, unsigned, registered
//  busy       out  1      high in every state except IDLE
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; P=0; out_valid=0; in_ready=1; busy=0; operand/partial regs=0.
//  - States: IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> DONE -> IDLE.
//  - IDLE: in_ready=1. On in_valid&&in_ready: latch aL=A[H-1:0], aH=A[W-1:H], bL, bH. Go to MUL_LO.
//  - MUL_LO: shared multiplier gets {0,aL}x{0,bL}; z0 <= product[W-1:0]. Go to MUL_HI.
//  - MUL_HI: multiplier gets {0,aH}x{0,bH}; z2 <= product[W-1:0]. Go to MUL_MID.
//  - MUL_MID: multiplier gets sa=(aL+aH), sb=(bL+bH), each H+1 bits (carry kept).
//    zm = sa*sb is W+2 bits; z1 = zm - z0 - z2 (W+2 bits, never negative).
//    P <= (z2<<W) + (z1<<H) + z0, all in 2W bits, no overflow. out_valid<=1. Go to DONE.
//  - DONE: out_valid=1, P held stable. On out_ready: out_valid<=0, go to IDLE. P keeps its value until the next MUL_MID.
//  - Latency: accept edge at t -> out_valid high after edge t+3. Min initiation interval 5 cycles
//    (accept, 3 passes, handoff); IDLE lasts >= 1 cycle between jobs.
//  - in_valid while busy: ignored, no latch, no side effect (in_ready=0).
//  - A,B may change freely after the accept edge; only latched copies are used.
//  - out_ready while not DONE: ignored. Backpressure in DONE has no limit.
//  - Multiplier mux select decodes from state only. Multiplier inputs are driven to 0 in IDLE/DONE (no toggling).
//  - rst asserted mid-job: job is discarded, no out_valid pulse; after release the block is IDLE and ready at once.
// STRUCTURE
//  - Shared package kara_pkg: W/H localparams, state enum encoding (IDLE=0, MUL_LO=1, MUL_HI=2,
//    MUL_MID=3, DONE=4, 3-bit), function kara_combine(z0,z2,zm) for the recombination arithmetic.
//  - Sub-module mult33_wt: combinational unsigned (H+1)x(H+1)->(W+2) Wallace-tree multiplier,
//    instantiated once. The top holds the FSM, operand/partial registers and recombination.
// TESTING
//  - A=0,B=0 -> P=0; out_valid exactly 3 edges after accept; in_ready low for 4 cycles.
//  - A=B=64'hFFFF_FFFF_FFFF_FFFF -> P=128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001 (sa/sb carry path).
//  - A=64'h0000_0001_0000_0000, B=64'h0000_0000_FFFF_FFFF -> P=128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000.
//  - Backpressure: out_ready=0 for 10 cycles after out_valid -> P, out_valid stable; in_valid pulses
//    ignored; then out_ready=1 -> IDLE next edge, next operands accepted.
//  - rst pulse during MUL_HI -> all outputs 0 / in_ready=1 at once; no stale product; next job correct.
//  - 500 random pairs A={2{$urandom(seed)}}, B likewise, seed=7, random out_ready stalls ->
//    P==A*B each time; CSV log "A, B, P" in decimal to kara64_seq_ctrl_output.csv.

Source files
------------

// File: rtl/kara_pkg.sv
// Shared widths, sequencer state encoding and Karatsuba recombination for the
// 64x64 multiplier.
package kara_pkg;

  localparam int W = 64;
  localparam int H = W / 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_LO  = 3'd1,
    MUL_HI  = 3'd2,
    MUL_MID = 3'd3,
    DONE    = 3'd4
  } state_t;

  // z1 = zm - z0 - z2 cannot go negative because zm = (aL+aH)(bL+bH) >= aL*bL + aH*bH.
  function automatic logic [2*W-1:0] kara_combine(
    input logic [W-1:0] z0,
    input logic [W-1:0] z2,
    input logic [W+1:0] zm
  );
    logic [W+1:0]   w_z1;
    logic [2*W-1:0] w_hi;
    logic [2*W-1:0] w_mid;
    logic [2*W-1:0] w_lo;
    w_z1  = zm - {2'b00, z0} - {2'b00, z2};
    w_hi  = {z2, {W{1'b0}}};
    w_mid = {{(W-2){1'b0}}, w_z1} << H;
    w_lo  = {{W{1'b0}}, z0};
    return w_hi + w_mid + w_lo;
  endfunction

endpackage

// File: rtl/mult33_wt.sv
// Combinational unsigned (H+1)x(H+1) multiplier: partial products reduced with
// 3:2 carry-save layers until two rows remain, then one final adder.
module mult33_wt
  import kara_pkg::*;
(
  input  logic [H:0]   i_a,
  input  logic [H:0]   i_b,
  output logic [W+1:0] o_p
);

  localparam int N      = H + 1;
  localparam int STAGES = 10;

  logic [W+1:0] r_rows [N];
  logic [W+1:0] w_x, w_y, w_z;
  int           w_n;
  int           w_m;

  always_comb begin
    w_x = '0;
    w_y = '0;
    w_z = '0;
    w_n = N;
    w_m = 0;
    for (int i = 0; i < N; i++) begin
      r_rows[i] = i_b[i] ? ({{(W+1-H){1'b0}}, i_a} << i) : '0;
    end
    // Each layer compresses every full group of three rows into a sum and a carry row.
    for (int s = 0; s < STAGES; s++) begin
      if (w_n > 2) begin
        w_m = 0;
        for (int g = 0; g < N / 3; g++) begin
          if (3 * g + 2 < w_n) begin
            w_x = r_rows[3*g];
            w_y = r_rows[3*g+1];
            w_z = r_rows[3*g+2];
            r_rows[w_m]   = w_x ^ w_y ^ w_z;
            r_rows[w_m+1] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
            w_m = w_m + 2;
          end
        end
        for (int j = 0; j < N; j++) begin
          if (j >= 3 * (w_n / 3) && j < w_n) begin
            r_rows[w_m] = r_rows[j];
            w_m = w_m + 1;
          end
        end
        w_n = w_m;
      end
    end
    o_p = r_rows[0] + r_rows[1];
  end

endmodule

// File: rtl/kara64_seq_ctrl.sv
// Three-pass Karatsuba sequencer for an unsigned 64x64->128 product through one
// shared 33x33 multiplier, with valid/ready handshakes on both sides.
module kara64_seq_ctrl
  import kara_pkg::*;
(
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_in_valid,
  output logic           o_in_ready,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*W-1:0] o_p,
  output logic           o_busy
);

  state_t         r_state;
  state_t         w_next;
  logic [H-1:0]   r_al, r_ah, r_bl, r_bh;
  logic [W-1:0]   r_z0, r_z2;
  logic [2*W-1:0] r_p;
  logic [H:0]     w_ma, w_mb;
  logic [W+1:0]   w_prod;
  logic           w_accept;

  assign w_accept = i_in_valid && (r_state == IDLE);

  mult33_wt u_mult (
    .i_a (w_ma),
    .i_b (w_mb),
    .o_p (w_prod)
  );

  // Operand select depends on state alone; held at zero outside the three passes.
  always_comb begin
    w_ma = '0;
    w_mb = '0;
    case (r_state)
      MUL_LO: begin
        w_ma = {1'b0, r_al};
        w_mb = {1'b0, r_bl};
      end
      MUL_HI: begin
        w_ma = {1'b0, r_ah};
        w_mb = {1'b0, r_bh};
      end
      MUL_MID: begin
        w_ma = {1'b0, r_al} + {1'b0, r_ah};
        w_mb = {1'b0, r_bl} + {1'b0, r_bh};
      end
      default: ;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = MUL_LO;
      MUL_LO:  w_next = MUL_HI;
      MUL_HI:  w_next = MUL_MID;
      MUL_MID: w_next = DONE;
      DONE:    if (i_out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_al    <= '0;
      r_ah    <= '0;
      r_bl    <= '0;
      r_bh    <= '0;
      r_z0    <= '0;
      r_z2    <= '0;
      r_p     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_al <= i_a[H-1:0];
        r_ah <= i_a[W-1:H];
        r_bl <= i_b[H-1:0];
        r_bh <= i_b[W-1:H];
      end
      if (r_state == MUL_LO) r_z0 <= w_prod[W-1:0];
      if (r_state == MUL_HI) r_z2 <= w_prod[W-1:0];
      if (r_state == MUL_MID) r_p <= kara_combine(r_z0, r_z2, w_prod);
    end
  end

  assign o_p         = r_p;
  assign o_out_valid = (r_state == DONE);
  assign o_in_ready  = (r_state == IDLE);
  assign o_busy      = (r_state != IDLE);

endmodule

// File: tb/tb_kara64_seq_ctrl.sv
// Randomized self-checking bench for kara64_seq_ctrl; expected products come
// from a plain 128-bit multiply of the offered operands.
module tb_kara64_seq_ctrl;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  a, b;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] p;
  logic         busy;

  int n_total = 0;
  int n_bad   = 0;

  kara64_seq_ctrl dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_a         (a),
    .i_b         (b),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_p         (p),
    .o_busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    logic [127:0] xx, yy;
    xx = {64'd0, x};
    yy = {64'd0, y};
    return xx * yy;
  endfunction

  // One full job: offer, wait for result, hold it under backpressure, then hand off.
  task automatic run_job(input logic [63:0] av, input logic [63:0] bv,
                         input int stall, input bit pulse_in);
    logic [127:0] exp;
    int           cnt;
    int           n_lo;
    exp  = ref_mul(av, bv);
    cnt  = 0;
    n_lo = 0;
    @(negedge clk);
    check("ready_before", {127'd0, in_ready}, 128'd1);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = {$urandom(), $urandom()};
    b        = {$urandom(), $urandom()};
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (!in_ready) n_lo++;
      if (out_valid) break;
      @(posedge clk);
      cnt++;
    end
    check("latency", 128'(cnt), 128'd3);
    check("ready_low_cycles", 128'(n_lo), 128'd4);
    check("product", p, exp);
    for (int s = 0; s < stall; s++) begin
      if (pulse_in) begin
        in_valid = 1'b1;
        a        = {$urandom(), $urandom()};
        b        = {$urandom(), $urandom()};
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("stall_valid", {127'd0, out_valid}, 128'd1);
      check("stall_ready", {127'd0, in_ready}, 128'd0);
      check("stall_p", p, exp);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("handoff_valid", {127'd0, out_valid}, 128'd0);
    check("handoff_ready", {127'd0, in_ready}, 128'd1);
    check("handoff_p", p, exp);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic [127:0] held;
    int           seen_valid;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    #1;
    check("rst_p", p, 128'd0);
    check("rst_valid", {127'd0, out_valid}, 128'd0);
    check("rst_ready", {127'd0, in_ready}, 128'd1);
    check("rst_busy", {127'd0, busy}, 128'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run_job(64'd0, 64'd0, 0, 1'b0);
    check("zero_p", p, 128'd0);
    run_job(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    check("ones_p", p, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    run_job(64'h0000_0001_0000_0000, 64'h0000_0000_FFFF_FFFF, 0, 1'b0);
    check("cross_p", p, 128'h0000_0000_0000_0000_FFFF_FFFF_0000_0000);
    run_job(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 10, 1'b1);

    // Reset during the high pass: everything clears immediately, no result appears.
    held = p;
    @(negedge clk);
    in_valid = 1'b1;
    a        = 64'hDEAD_BEEF_CAFE_F00D;
    b        = 64'h0123_4567_89AB_CDEF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("pre_rst_busy", {127'd0, busy}, 128'd1);
    rst = 1'b1;
    #1;
    check("midrst_p", p, 128'd0);
    check("midrst_valid", {127'd0, out_valid}, 128'd0);
    check("midrst_ready", {127'd0, in_ready}, 128'd1);
    check("midrst_busy", {127'd0, busy}, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("postrst_ready", {127'd0, in_ready}, 128'd1);
    seen_valid = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen_valid++;
    end
    check("no_stale_valid", 128'(seen_valid), 128'd0);
    check("no_stale_p", p, 128'd0);
    if (held == 128'd0) check("held_nonzero", held, 128'd1);
    run_job(64'hDEAD_BEEF_CAFE_F00D, 64'h0123_4567_89AB_CDEF, 0, 1'b0);

    void'($urandom(7));
    for (int i = 0; i < 500; i++) begin
      ra = {$urandom(), $urandom()};
      rb = {$urandom(), $urandom()};
      run_job(ra, rb, int'($urandom_range(0, 3)), ($urandom_range(0, 1) == 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
